// File: rtl/opl_timer_pkg.sv
// rtl/opl_timer_pkg.sv - shared constants and state types for the OPL timer bank
//
// Purpose: control/status bit positions, default register indices and the
// per-timer state record used by opl_timer_ch.
// Ports: none (package).

package opl_timer_pkg;

  // Control register bit positions
  localparam int CLR_BIT    = 7;  // 1 = clear all flags, leave masks/starts alone
  localparam int START_BIT0 = 0;  // start of timer i at bit START_BIT0+i
  localparam int MASK_BIT0  = 6;  // mask of timer i at bit MASK_BIT0-i

  // Status byte bit positions
  localparam int STAT_ANY_BIT   = 7;  // OR of all flags
  localparam int STAT_FLAG_BIT0 = 6;  // flag of timer i at bit STAT_FLAG_BIT0-i

  // Default register indices (index space is 9 bits: {bank, din})
  localparam logic [8:0] DEF_PRESET_IDX0 = 9'h002;
  localparam logic [8:0] DEF_CTRL_IDX    = 9'h004;

  // Storage widths of the state record; the channel uses the low bits it needs
  // and keeps the upper bits at zero.
  localparam int CNT_MAX_W = 8;
  localparam int SUB_MAX_W = 32;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] counter;
    logic [SUB_MAX_W-1:0] sub;
    logic                 start_q;
  } timer_state_t;

endpackage

// File: rtl/opl_timer_ch.sv
// rtl/opl_timer_ch.sv - one up-counting OPL timer with tick prescaler and auto-reload
//
// Purpose: tick prescaler (sub) plus CNT_W-bit up counter. On overflow the
// counter reloads from preset and ovf_pulse is high for one clk.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       timer run enable (level); a rising edge reloads counter and sub
//   preset      counter reload value
//   res         tick resolution; one tick lasts res+1 clocks
//   ovf_pulse   one-clk pulse per overflow, registered

module opl_timer_ch
  import opl_timer_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RES_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] preset,
  input  logic [RES_W-1:0] res,
  output logic             ovf_pulse
);

  localparam logic [CNT_MAX_W-1:0] CNT_TOP = CNT_MAX_W'((1 << CNT_W) - 1);

  timer_state_t         st;
  logic [CNT_MAX_W-1:0] preset_ext;
  logic [SUB_MAX_W-1:0] res_ext;
  logic                 load;
  logic                 tick;
  logic                 wrap;

  assign preset_ext = CNT_MAX_W'(preset);
  assign res_ext    = SUB_MAX_W'(res);

  // Rising start takes precedence over everything; a tick only happens on a
  // channel that was already running in the previous clk.
  assign load = start & ~st.start_q;
  assign tick = start & st.start_q & (st.sub == '0);
  assign wrap = tick & (st.counter == CNT_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      st.start_q <= start;
      ovf_pulse  <= wrap;
      if (load) begin
        st.counter <= preset_ext;
        st.sub     <= res_ext;
      end else if (tick) begin
        // period_base is sampled here, so base changes land at the next tick
        st.sub     <= res_ext;
        st.counter <= wrap ? preset_ext : st.counter + CNT_MAX_W'(1);
      end else if (start) begin
        st.sub <= st.sub - SUB_MAX_W'(1);
      end
    end
  end

endmodule

// File: rtl/opl_timer_bank.sv
// rtl/opl_timer_bank.sv - OPL/AdLib-compatible timer bank with register decode, status and IRQ
//
// Purpose: index/data register decode, NUM_TIMERS timer channels, overflow
// flags, status byte, IRQ and the status-polling fallback that forces flags
// when software polls status many times without seeing a timer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   period_base  base tick length in clk cycles minus one
//   addr         bit0: 0 = index write, 1 = data write; bit1 = index bit 8
//   din          write data
//   we           write strobe (level, rising edge acts)
//   rd           status read strobe (level, rising edge counted)
//   dout         status: bit7 = any flag, bit(6-i) = flag of timer i
//   irq_n        low while any flag is set
//   ovf_pulse    raw one-clk overflow pulse per timer, before masking

module opl_timer_bank
  import opl_timer_pkg::*;
#(
  parameter int         NUM_TIMERS     = 2,
  parameter int         CNT_W          = 8,
  parameter int         BASE_W         = 13,
  parameter int         SHIFT_STEP     = 2,
  parameter logic [8:0] PRESET_IDX0    = DEF_PRESET_IDX0,
  parameter logic [8:0] CTRL_IDX       = DEF_CTRL_IDX,
  parameter int         POLL_FORCE_CNT = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BASE_W-1:0]     period_base,
  input  logic [1:0]            addr,
  input  logic [7:0]            din,
  input  logic                  we,
  input  logic                  rd,
  output logic [7:0]            dout,
  output logic                  irq_n,
  output logic [NUM_TIMERS-1:0] ovf_pulse
);

  localparam int         RES_W    = BASE_W + (NUM_TIMERS - 1) * SHIFT_STEP;
  localparam int         WIN_W    = BASE_W + 10;
  localparam logic [5:0] FORCE_AT = 6'(POLL_FORCE_CNT);
  localparam logic [5:0] RD_SAT   = 6'h3f;

  logic                  we_q;
  logic                  rd_q;
  logic                  wr;
  logic                  rd_edge;
  logic                  data_wr;
  logic                  ctrl_wr;
  logic                  flag_clr;
  logic [8:0]            index;
  logic [CNT_W-1:0]      preset [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] start;
  logic [NUM_TIMERS-1:0] mask;
  logic [NUM_TIMERS-1:0] flag;
  logic [NUM_TIMERS-1:0] flag_set;
  logic [WIN_W-1:0]      window;
  logic [5:0]            rdcnt;
  logic                  force_pulse;
  logic [RES_W-1:0]      base_ext;

  assign wr       = we & ~we_q;
  assign rd_edge  = rd & ~rd_q;
  assign data_wr  = wr & addr[0];
  assign ctrl_wr  = data_wr & (index == CTRL_IDX);
  assign flag_clr = ctrl_wr & din[CLR_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      we_q <= we;
      rd_q <= rd;
    end
  end

  // Register decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      start <= '0;
      mask  <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) preset[i] <= '0;
    end else begin
      if (wr && !addr[0]) index <= {addr[1], din};
      if (ctrl_wr && !din[CLR_BIT]) begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
          start[i] <= din[START_BIT0 + i];
          mask[i]  <= din[MASK_BIT0 - i];
        end
      end
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (data_wr && index == PRESET_IDX0 + 9'(i)) preset[i] <= din[CNT_W-1:0];
      end
    end
  end

  // Flags: a set in the same clk as a clear wins; masking never clears.
  assign flag_set = (ovf_pulse | {NUM_TIMERS{force_pulse}}) & ~mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag <= '0;
    else        flag <= flag_set | (flag & ~{NUM_TIMERS{flag_clr}});
  end

  // Poll fallback: rapid status reads without any gap of about period_base
  // kilo-clocks eventually force the flags, for software that polls instead
  // of waiting for the IRQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window      <= '0;
      rdcnt       <= '0;
      force_pulse <= 1'b0;
    end else if (rd_edge) begin
      window      <= '0;
      force_pulse <= (rdcnt == FORCE_AT);
      if (rdcnt != RD_SAT) rdcnt <= rdcnt + 6'd1;
    end else begin
      force_pulse <= 1'b0;
      if (window[WIN_W-1:10] >= period_base || ctrl_wr) begin
        window <= '0;
        rdcnt  <= '0;
      end else begin
        window <= window + WIN_W'(1);
      end
    end
  end

  always_comb begin
    dout               = '0;
    dout[STAT_ANY_BIT] = |flag;
    for (int i = 0; i < NUM_TIMERS; i++) dout[STAT_FLAG_BIT0 - i] = flag[i];
  end

  assign irq_n = ~|flag;

  assign base_ext = RES_W'(period_base);

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_tmr
    logic [RES_W-1:0] res;
    assign res = base_ext << (g * SHIFT_STEP);

    opl_timer_ch #(
      .CNT_W (CNT_W),
      .RES_W (RES_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .preset    (preset[g]),
      .res       (res),
      .ovf_pulse (ovf_pulse[g])
    );
  end

endmodule

// File: tb/tb_opl_timer_bank.sv
// tb/tb_opl_timer_bank.sv - self-checking bench for opl_timer_bank

module tb_opl_timer_bank;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [12:0]   period_base = '0;
  logic [1:0]    addr = '0;
  logic [7:0]    din = '0;
  logic          we = 1'b0;
  logic          rd = 1'b0;
  logic [7:0]    dout;
  logic          irq_n;
  logic [NT-1:0] ovf_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  opl_timer_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .period_base (period_base),
    .addr        (addr),
    .din         (din),
    .we          (we),
    .rd          (rd),
    .dout        (dout),
    .irq_n       (irq_n),
    .ovf_pulse   (ovf_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0; rd = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic reg_wr(input logic [8:0] idx, input logic [7:0] d);
    logic [7:0] lo;
    lo = idx[7:0];
    bus_wr({idx[8], 1'b0}, lo);
    bus_wr({idx[8], 1'b1}, d);
  endtask

  task automatic rd_pulse(input int gap);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_pulse(input int j, input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (ovf_pulse[j]) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic [12:0] pb;
    int          tmr;
    logic [7:0]  preset;
    logic [7:0]  ctrl;
    int          period;
    logic [7:0]  dout_exp;
    logic        irq_exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          t1, t2, j, pb, pre, msk, per, e0, seen;
    bit          ok, exp_p, prev_p, flag_m;
    logic [7:0]  ctrl_v, dexp;

    // {period_base, timer, preset, ctrl, overflow period in clk, dout after first pulse, irq_n}
    vecs[0] = '{13'd3, 0, 8'hFE, 8'h01,  8, 8'hC0, 1'b0};
    vecs[1] = '{13'd3, 1, 8'hFF, 8'h02, 13, 8'hA0, 1'b0};
    vecs[2] = '{13'd3, 0, 8'hFF, 8'h41,  4, 8'h00, 1'b1};
    vecs[3] = '{13'd0, 0, 8'hFD, 8'h01,  3, 8'hC0, 1'b0};
    vecs[4] = '{13'd2, 1, 8'hFE, 8'h02, 18, 8'hA0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_irq_n", 32'(irq_n), 32'h1);
    check("rst_ovf", 32'(ovf_pulse), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_ovf", 32'(ovf_pulse), 32'h0);

    // Table-driven single-timer runs
    for (int v = 0; v < 5; v++) begin
      do_reset();
      period_base = vecs[v].pb;
      reg_wr(9'h002 + 9'(vecs[v].tmr), vecs[v].preset);
      reg_wr(9'h004, vecs[v].ctrl);
      wait_pulse(vecs[v].tmr, 3000, t1, ok);
      check($sformatf("vec%0d_first_pulse", v), 32'(ok), 32'h1);
      @(negedge clk);
      check($sformatf("vec%0d_dout", v), 32'(dout), 32'(vecs[v].dout_exp));
      check($sformatf("vec%0d_irq_n", v), 32'(irq_n), 32'(vecs[v].irq_exp));
      wait_pulse(vecs[v].tmr, 3000, t2, ok);
      check($sformatf("vec%0d_period", v), 32'(t2 - t1), 32'(vecs[v].period));
    end

    // Clear colliding with a flag set: set wins
    do_reset();
    period_base = 13'd3;
    reg_wr(9'h002, 8'hFE);
    reg_wr(9'h004, 8'h01);
    wait_pulse(0, 200, t1, ok);
    wait_pulse(0, 200, t2, ok);
    check("collide_pulse_seen", 32'(ok), 32'h1);
    addr = 2'b01; din = 8'h80; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    check("clr_vs_set_dout", 32'(dout), 32'hC0);
    // Quiet clear
    bus_wr(2'b01, 8'h80);
    check("quiet_clr_dout", 32'(dout), 32'h00);
    check("quiet_clr_irq_n", 32'(irq_n), 32'h1);
    // Masking keeps an already-set flag
    wait_pulse(0, 200, t1, ok);
    @(negedge clk);
    check("flag_before_mask", 32'(dout), 32'hC0);
    reg_wr(9'h004, 8'h41);
    check("mask_keeps_flag", 32'(dout), 32'hC0);

    // Asynchronous reset mid-run with a flag set
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout), 32'h00);
    check("async_rst_irq_n", 32'(irq_n), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (ovf_pulse != '0) seen++;
    end
    check("no_pulse_after_rst", 32'(seen), 32'h0);

    // Poll fallback: 21st rapid read edge forces unmasked flags
    do_reset();
    period_base = 13'd3;
    repeat (20) rd_pulse(8);
    check("poll_20_no_force", 32'(dout), 32'h00);
    rd_pulse(8);
    check("poll_force", 32'(dout), 32'hE0);
    check("poll_force_irq_n", 32'(irq_n), 32'h0);

    // Force respects masks
    do_reset();
    reg_wr(9'h004, 8'h40);
    repeat (21) rd_pulse(8);
    check("poll_force_masked", 32'(dout), 32'hA0);

    // Long gap resets the read count
    do_reset();
    repeat (20) rd_pulse(8);
    repeat (3100) @(negedge clk);
    rd_pulse(8);
    check("poll_gap_no_force", 32'(dout), 32'h00);

    // Control write resets the read count
    do_reset();
    repeat (20) rd_pulse(8);
    reg_wr(9'h004, 8'h00);
    rd_pulse(8);
    check("poll_ctrl_no_force", 32'(dout), 32'h00);

    // Randomized runs against a closed-form model: after the start is seen at
    // clk e0, overflows land at e0 + k*(R+1)*(256-preset), k >= 1.
    do_reset();
    for (int it = 0; it < 8; it++) begin
      j   = int'($urandom_range(0, 1));
      pb  = int'($urandom_range(0, 5));
      pre = int'($urandom_range(8'hF8, 8'hFF));
      msk = int'($urandom_range(0, 1));
      reg_wr(9'h004, 8'h00);
      reg_wr(9'h004, 8'h80);
      period_base = 13'(pb);
      reg_wr(9'h002 + 9'(j), 8'(pre));
      ctrl_v = 8'(1 << j) | 8'(msk << (6 - j));
      reg_wr(9'h004, ctrl_v);
      e0     = cyc + 1;
      per    = ((pb << (2 * j)) + 1) * (256 - pre);
      prev_p = 1'b0;
      flag_m = 1'b0;
      dexp   = 8'h80 | (8'h40 >> j);
      repeat (2 * per + 4) begin
        @(negedge clk);
        exp_p  = (cyc > e0) && (((cyc - e0) % per) == 0);
        flag_m = flag_m | (prev_p & (msk == 0));
        check($sformatf("rnd%0d_ovf", it), 32'(ovf_pulse[j]), 32'(exp_p));
        check($sformatf("rnd%0d_ovf_other", it), 32'(ovf_pulse[1-j]), 32'h0);
        check($sformatf("rnd%0d_dout", it), 32'(dout), flag_m ? 32'(dexp) : 32'h0);
        prev_p = exp_p;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
